// File: rtl/program_loader.sv
// program_loader: boot-time controller that receives a program over a UART
// byte stream, writes big-endian 32-bit words into instruction memory at the
// current PC, then rewinds the PC and releases the core.
// Optional feature: define PROGRAM_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte (CHECK state) before the core is released.
module program_loader #(
    parameter int INST_WIDTH     = 32,
    parameter int INST_MEM_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    reload,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    we,
    output logic                    reset_pc,
    output logic                    stall,
    output logic                    loading,
    output logic                    running,
    output logic                    error,
    output logic [INST_MEM_WIDTH:0] words_loaded
);
    localparam int                    CW        = INST_MEM_WIDTH + 1;
    localparam logic [INST_WIDTH-1:0] MAX_WORDS = INST_WIDTH'(1) << INST_MEM_WIDTH;
    localparam logic [CW-1:0]         ONE_W     = {{INST_MEM_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_HEADER = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_ERROR  = 3'd4,
        ST_CHECK  = 3'd5
`else
        ST_ERROR  = 3'd4
`endif
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR fold of one byte into the checksum accumulator.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`endif

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d, cnt_step_s;
    logic [23:0]             shift_q, shift_d;
    logic [CW-1:0]           n_q, n_d;
    logic [CW-1:0]           wl_q, wl_d;
    logic [INST_WIDTH-1:0]   inst_in_q, inst_in_d;
    logic                    we_q, we_d;
    logic                    reset_pc_q, reset_pc_d;
    logic                    stall_q, stall_d;
    logic                    loading_q, loading_d;
    logic                    running_q, running_d;
    logic                    error_q, error_d;
    logic [INST_WIDTH-1:0]   word_s;
    logic                    byte_take_s;
    logic                    word_done_s;
    logic                    reload_take_s;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
    logic                    pend_q, pend_d;
    logic                    match_q, match_d;
`endif

    // Next-state logic, byte assembly and staging of every registered output.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        n_d           = n_q;
        wl_d          = wl_q;
        inst_in_d     = inst_in_q;
        we_d          = 1'b0;
        reload_take_s = 1'b0;
        cnt_step_s    = cnt_q;
        word_s        = {shift_q, rx_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        csum_d        = csum_q;
        pend_d        = pend_q;
        match_d       = match_q;
`endif
        // Bytes are only assembled while a header or an unfinished body is expected.
        if (rx_valid && (state_q == ST_HEADER)) begin
            byte_take_s = 1'b1;
        end else if (rx_valid && (state_q == ST_LOAD) && (wl_q != n_q)) begin
            byte_take_s = 1'b1;
        end else begin
            byte_take_s = 1'b0;
        end
        word_done_s = byte_take_s && (cnt_q == 2'd3);

        if (byte_take_s) begin
            cnt_step_s = cnt_q + 2'd1;
            shift_d    = {shift_q[15:0], rx_data};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_d     = csum_fold(csum_q, rx_data);
`endif
        end else begin
            cnt_step_s = cnt_q;
        end

        case (state_q)
            ST_HEADER: begin
                if (word_done_s) begin
                    n_d = word_s[CW-1:0];
                    if (word_s == {INST_WIDTH{1'b0}}) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_START;
`endif
                    end else if (word_s > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_HEADER;
                end
            end
            ST_LOAD: begin
                if (wl_q == n_q) begin
                    // Cycle after the last write: the PC has advanced past the program.
                    state_d = ST_START;
                end else if (word_done_s) begin
                    inst_in_d = word_s;
                    we_d      = 1'b1;
                    wl_d      = wl_q + ONE_W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    // Enter CHECK during the last write so a back-to-back checksum byte is caught.
                    if ((wl_q + ONE_W) == n_q) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_LOAD;
                    end
`endif
                end else begin
                    state_d = ST_LOAD;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = match_q ? ST_START : ST_ERROR;
                end else if (rx_valid) begin
                    pend_d  = 1'b1;
                    match_d = (rx_data == csum_q);
                end else begin
                    state_d = ST_CHECK;
                end
            end
`endif
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_ERROR: begin
                if (reload) begin
                    reload_take_s = 1'b1;
                    state_d       = ST_HEADER;
                    wl_d          = {CW{1'b0}};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    csum_d        = 8'h00;
                    pend_d        = 1'b0;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_HEADER;
            end
        endcase

        // The byte counter restarts on every state entry.
        cnt_d      = (state_d != state_q) ? 2'd0 : cnt_step_s;
        stall_d    = ~((state_d == ST_RUN) | we_d);
        reset_pc_d = (state_d == ST_START) | reload_take_s;
        loading_d  = (state_d == ST_HEADER) | (state_d == ST_LOAD);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        loading_d  = loading_d | (state_d == ST_CHECK);
`endif
        running_d  = (state_d == ST_RUN);
        error_d    = (state_d == ST_ERROR);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HEADER;
            cnt_q      <= 2'd0;
            shift_q    <= 24'd0;
            n_q        <= {CW{1'b0}};
            wl_q       <= {CW{1'b0}};
            inst_in_q  <= {INST_WIDTH{1'b0}};
            we_q       <= 1'b0;
            reset_pc_q <= 1'b1;
            stall_q    <= 1'b1;
            loading_q  <= 1'b1;
            running_q  <= 1'b0;
            error_q    <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
            pend_q     <= 1'b0;
            match_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            n_q        <= n_d;
            wl_q       <= wl_d;
            inst_in_q  <= inst_in_d;
            we_q       <= we_d;
            reset_pc_q <= reset_pc_d;
            stall_q    <= stall_d;
            loading_q  <= loading_d;
            running_q  <= running_d;
            error_q    <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            pend_q     <= pend_d;
            match_q    <= match_d;
`endif
        end
    end

    assign inst_in      = inst_in_q;
    assign we           = we_q;
    assign reset_pc     = reset_pc_q;
    assign stall        = stall_q;
    assign loading      = loading_q;
    assign running      = running_q;
    assign error        = error_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized programs compared
// against a byte-level reference model of the load protocol.
`timescale 1ns/1ps
module tb_program_loader;
    localparam int AW  = 12;
    localparam int CAP = 1 << AW;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        reload = 1'b0;
    logic [31:0] inst_in;
    logic        we, reset_pc, stall, loading, running, error;
    logic [AW:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] prog_words[$];

    // Monitor records.
    logic [31:0] we_data_q[$];
    int          we_cyc_q[$];
    int          we_wl_q[$];
    int          rpc_cyc_q[$];
    int          stall_bad = 0;

    program_loader #(.INST_WIDTH(32), .INST_MEM_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .reload(reload), .inst_in(inst_in), .we(we), .reset_pc(reset_pc),
        .stall(stall), .loading(loading), .running(running), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k after the k-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor of write pulses, PC rewinds and the stall rule (stall low only on we or RUN).
    always @(negedge clk) begin
        if (we === 1'b1) begin
            we_data_q.push_back(inst_in);
            we_cyc_q.push_back(cyc);
            we_wl_q.push_back(int'(words_loaded));
        end
        if (reset_pc === 1'b1) rpc_cyc_q.push_back(cyc);
        if (stall !== ~(we | running)) stall_bad <= stall_bad + 1;
    end

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            reload   = 1'b0;
        end
    endtask

    // Drive one byte; edge_c is the rising edge that samples it.
    task automatic send_byte(input logic [7:0] b, output int edge_c);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        edge_c   = cyc + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b0; reload = 1'b0;
        idle(3);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        n_tests++;
        if ({stall, reset_pc, we, loading, running, error} !== 6'b110100 || inst_in !== 32'h0 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got flags=%b inst=%h wl=%0d expected flags=110100 inst=0 wl=0",
                     {stall, reset_pc, we, loading, running, error}, inst_in, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (reset_pc !== 1'b0 || stall !== 1'b1 || loading !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got reset_pc=%b stall=%b loading=%b expected 0 1 1", reset_pc, stall, loading);
        end
    endtask

    // Load prog_words and check writes, timing, count and release against the model.
    task automatic test_program_load(input string name, input int gap_max, input bit do_rst);
        logic [7:0]  bq[$];
        int          eq[$];
        logic [31:0] nv;
        logic [31:0] w;
        logic [7:0]  cs;
        int n, e, base_we, base_bad, run_cyc, n_we, data_err, time_err, wl_err, hits;
        n  = prog_words.size();
        nv = n;
        bq.push_back(nv[31:24]); bq.push_back(nv[23:16]); bq.push_back(nv[15:8]); bq.push_back(nv[7:0]);
        foreach (prog_words[i]) begin
            w = prog_words[i];
            bq.push_back(w[31:24]); bq.push_back(w[23:16]); bq.push_back(w[15:8]); bq.push_back(w[7:0]);
        end
        cs = 8'h00;
        foreach (bq[i]) cs = cs ^ bq[i];
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        bq.push_back(cs);
`endif
        if (do_rst) do_reset();
        base_we  = we_data_q.size();
        base_bad = stall_bad;
        foreach (bq[i]) begin
            idle($urandom_range(0, gap_max));
            send_byte(bq[i], e);
            eq.push_back(e);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        run_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (running === 1'b1) begin
                run_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        n_we = we_data_q.size() - base_we;
        data_err = 0; time_err = 0; wl_err = 0;
        for (int i = 0; i < n && i < n_we; i++) begin
            if (we_data_q[base_we + i] !== prog_words[i]) data_err++;
            if (we_cyc_q[base_we + i] != eq[4 + 4 * i + 3]) time_err++;
            if (we_wl_q[base_we + i] != i + 1) wl_err++;
        end
        n_tests++;
        if (n_we != n) begin
            n_fail++;
            $display("FAIL %s we_count: got %0d expected %0d", name, n_we, n);
        end
        n_tests++;
        if (data_err != 0) begin
            n_fail++;
            $display("FAIL %s we_data: got %0d mismatching words expected 0", name, data_err);
        end
        n_tests++;
        if (time_err != 0) begin
            n_fail++;
            $display("FAIL %s we_timing: got %0d late/early pulses expected 0", name, time_err);
        end
        n_tests++;
        if (wl_err != 0) begin
            n_fail++;
            $display("FAIL %s words_loaded_step: got %0d wrong counts expected 0", name, wl_err);
        end
        n_tests++;
        if (run_cyc != eq[eq.size() - 1] + 2) begin
            n_fail++;
            $display("FAIL %s run_latency: got running at cycle %0d expected %0d", name, run_cyc, eq[eq.size() - 1] + 2);
        end
        n_tests++;
        if (words_loaded !== (AW + 1)'(n) || loading !== 1'b0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL %s final_state: got wl=%0d loading=%b error=%b expected wl=%0d loading=0 error=0",
                     name, words_loaded, loading, error, n);
        end
        hits = 0;
        foreach (rpc_cyc_q[i]) if (rpc_cyc_q[i] == run_cyc - 1) hits++;
        n_tests++;
        if (hits != 1) begin
            n_fail++;
            $display("FAIL %s start_reset_pc: got %0d pulses before RUN expected 1", name, hits);
        end
        n_tests++;
        if (stall_bad != base_bad) begin
            n_fail++;
            $display("FAIL %s stall_rule: got %0d bad stall cycles expected 0", name, stall_bad - base_bad);
        end
        idle(2);
    endtask

    task automatic test_gaps();
        prog_words = {32'h11223344, 32'hAABBCCDD};
        test_program_load("gaps", 4, 1'b1);
    endtask

    task automatic test_back_to_back();
        prog_words = {32'h11223344, 32'hAABBCCDD};
        test_program_load("back_to_back", 0, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            prog_words = {};
            for (int i = 0; i < int'($urandom_range(1, 16)); i++) prog_words.push_back($urandom);
            test_program_load("random", r % 3, 1'b1);
        end
    endtask

    task automatic test_full_capacity();
        prog_words = {};
        for (int i = 0; i < CAP; i++) prog_words.push_back($urandom);
        test_program_load("full_capacity", 0, 1'b1);
    endtask

    task automatic test_zero_header();
        int e, base_we, run_cyc, hits;
        do_reset();
        base_we = we_data_q.size();
        for (int i = 0; i < 4; i++) send_byte(8'h00, e);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h00, e);
`endif
        @(negedge clk);
        rx_valid = 1'b0;
        run_cyc = -1;
        for (int k = 0; k < 20; k++) begin
            if (running === 1'b1) begin
                run_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        hits = 0;
        foreach (rpc_cyc_q[i]) if (rpc_cyc_q[i] == run_cyc - 1) hits++;
        n_tests++;
        if (run_cyc < 0 || we_data_q.size() != base_we || hits != 1 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL zero_header: got run_cyc=%0d we=%0d start_pulse=%0d wl=%0d expected RUN, 0 we, 1 pulse, wl=0",
                     run_cyc, we_data_q.size() - base_we, hits, words_loaded);
        end
        idle(2);
    endtask

    task automatic test_oversize();
        int e, base_we;
        logic [31:0] nv;
        do_reset();
        base_we = we_data_q.size();
        nv = CAP + 1;
        send_byte(nv[31:24], e); send_byte(nv[23:16], e); send_byte(nv[15:8], e); send_byte(nv[7:0], e);
        for (int i = 0; i < 8; i++) send_byte($urandom, e);
        idle(3);
        n_tests++;
        if (error !== 1'b1 || stall !== 1'b1 || running !== 1'b0 || loading !== 1'b0 || we_data_q.size() != base_we) begin
            n_fail++;
            $display("FAIL oversize: got error=%b stall=%b running=%b loading=%b we=%0d expected 1 1 0 0 0",
                     error, stall, running, loading, we_data_q.size() - base_we);
        end
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        n_tests++;
        if (error !== 1'b0 || reset_pc !== 1'b1 || loading !== 1'b1) begin
            n_fail++;
            $display("FAIL oversize_reload: got error=%b reset_pc=%b loading=%b expected 0 1 1", error, reset_pc, loading);
        end
        idle(2);
    endtask

    task automatic test_reload();
        int e, base_we;
        prog_words = {$urandom, $urandom, $urandom};
        test_program_load("pre_reload", 1, 1'b1);
        base_we = we_data_q.size();
        for (int i = 0; i < 6; i++) send_byte($urandom, e);
        idle(3);
        n_tests++;
        if (we_data_q.size() != base_we || running !== 1'b1) begin
            n_fail++;
            $display("FAIL run_ignores_rx: got we=%0d running=%b expected 0 1", we_data_q.size() - base_we, running);
        end
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        n_tests++;
        if ({reset_pc, running, loading, stall, error} !== 5'b10110 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reload_entry: got flags=%b wl=%0d expected flags=10110 wl=0",
                     {reset_pc, running, loading, stall, error}, words_loaded);
        end
        @(negedge clk);
        n_tests++;
        if (reset_pc !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_pulse_width: got reset_pc=%b expected 0", reset_pc);
        end
        prog_words = {32'hDEADBEEF};
        test_program_load("reload_deadbeef", 2, 1'b0);
    endtask

    task automatic test_reset_mid_word();
        int e, base_we;
        do_reset();
        base_we = we_data_q.size();
        send_byte(8'h00, e); send_byte(8'h00, e); send_byte(8'h00, e); send_byte(8'h01, e);
        send_byte(8'hCA, e); send_byte(8'hFE, e);
        @(negedge clk);
        rx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({stall, reset_pc, we, loading, running, error} !== 6'b110100 || words_loaded !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_word: got flags=%b wl=%0d expected flags=110100 wl=0",
                     {stall, reset_pc, we, loading, running, error}, words_loaded);
        end
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        n_tests++;
        if (we_data_q.size() != base_we) begin
            n_fail++;
            $display("FAIL reset_mid_word_we: got %0d we pulses expected 0", we_data_q.size() - base_we);
        end
        prog_words = {$urandom};
        test_program_load("after_mid_reset", 1, 1'b0);
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int e, base_we;
        logic [7:0] good[$];
        good = {8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        foreach (good[i]) send_byte(good[i], e);
        send_byte(8'h05, e);
        idle(4);
        n_tests++;
        if (running !== 1'b1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_good: got running=%b error=%b expected 1 0", running, error);
        end
        do_reset();
        base_we = we_data_q.size();
        foreach (good[i]) send_byte(good[i], e);
        send_byte(8'h00, e);
        idle(4);
        n_tests++;
        if (error !== 1'b1 || running !== 1'b0 || stall !== 1'b1 || we_data_q.size() != base_we + 1) begin
            n_fail++;
            $display("FAIL checksum_bad: got error=%b running=%b stall=%b we=%0d expected 1 0 1 1",
                     error, running, stall, we_data_q.size() - base_we);
        end
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL checksum_reload: got error=%b expected 0", error);
        end
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_gaps();
        test_back_to_back();
        test_zero_header();
        test_oversize();
        test_random();
        test_reload();
        test_reset_mid_word();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_full_capacity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
